// File: rtl/systolic_result_collector.sv
// Result collector at the reader end of the systolic array output bus.
// The array delivers each row skewed in time: lane k arrives k array-steps
// after lane 0. This block delays every lane so the whole row lines up,
// pushes the aligned row into a show-ahead FIFO, and presents rows on a
// valid/ready stream.
//
// Handshake: a row transfers on any rising edge where Out_Valid and
// Out_Ready are both 1. Out_Valid never waits on Out_Ready. Out_Data is the
// FIFO head and stays stable while Out_Valid=1 and the row is not taken.
module systolic_result_collector #(
   parameter int LANES = 9,
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       En,
   input  logic                       In_Valid,
   input  logic [LANES*WIDTH-1:0]     Result,
   input  logic                       Flush,
   output logic [LANES*WIDTH-1:0]     Out_Data,
   output logic                       Out_Valid,
   input  logic                       Out_Ready,
   output logic [$clog2(DEPTH):0]     Level,
   output logic                       Overflow,
   output logic [7:0]                 Drop_Count,
   output logic                       Busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = LANES * WIDTH;

   // Row valid tag: bit j set means a row started j+1 array-steps ago.
   logic [LANES-2:0] tag_q;
   logic [RW-1:0]    row_aligned;

   // FIFO storage and status.
   logic [RW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_q;
   logic             overflow_q;
   logic [7:0]       drop_q;
   logic [RW-1:0]    hold_q;

   logic             clear;
   logic             push_req;
   logic             pop;
   logic             full;
   logic             push;
   logic             drop;

   assign clear = Rst | Flush;

   // Shift the row tag alongside the lane data; only advances with En.
   always_ff @(posedge Clk) begin
      if (clear) begin
         tag_q <= '0;
      end else if (En) begin
         tag_q <= {tag_q[LANES-3:0], In_Valid};
      end
   end

   // Lane k needs LANES-1-k delay stages; the last lane is used directly
   // from the bus on the edge the row completes.
   for (genvar k = 0; k < LANES - 1; k++) begin : g_lane
      logic [WIDTH-1:0] sr [LANES-1-k];

      // Per-lane delay line, frozen while En=0.
      always_ff @(posedge Clk) begin
         if (En) begin
            sr[0] <= Result[k*WIDTH +: WIDTH];
            for (int j = 1; j < LANES - 1 - k; j++) begin
               sr[j] <= sr[j-1];
            end
         end
      end

      assign row_aligned[k*WIDTH +: WIDTH] = sr[LANES-2-k];
   end

   assign row_aligned[(LANES-1)*WIDTH +: WIDTH] = Result[(LANES-1)*WIDTH +: WIDTH];

   // Push/pop decisions for this edge. A full FIFO still accepts a row when
   // the head leaves on the same edge.
   assign push_req = En & tag_q[LANES-2] & ~clear;
   assign pop      = Out_Valid & Out_Ready & ~clear;
   assign full     = (level_q == LW'(DEPTH));
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & ~push;

   // FIFO storage write; contents need no reset because level gates reads.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= row_aligned;
      end
   end

   // Pointers, level, overflow status and the held output value.
   always_ff @(posedge Clk) begin
      if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         hold_q     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 1'b1;
            end
         end
         hold_q <= Out_Data;
      end
   end

   // Show-ahead output: head row while non-empty, otherwise the last shown row.
   always_comb begin
      Out_Data = hold_q;
      if (level_q != '0) begin
         Out_Data = mem[rd_ptr];
      end
   end

   assign Out_Valid  = (level_q != '0);
   assign Level      = level_q;
   assign Overflow   = overflow_q;
   assign Drop_Count = drop_q;
   assign Busy       = (|tag_q) | (level_q != '0);

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: skewed row driver, negedge
// output monitor with an expected-row queue, and hand-computed status checks.
module tb_systolic_result_collector;

  localparam int L  = 9;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int RW = L * W;

  // clock/reset block
  logic          Clk = 1'b0;
  logic          Rst;
  logic          En;
  logic          In_Valid;
  logic [RW-1:0] Result;
  logic          Flush;
  logic [RW-1:0] Out_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [3:0]    Level;
  logic          Overflow;
  logic [7:0]    Drop_Count;
  logic          Busy;

  always #5 Clk = ~Clk;

  systolic_result_collector #(.LANES(L), .WIDTH(W), .DEPTH(D)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .In_Valid   (In_Valid),
    .Result     (Result),
    .Flush      (Flush),
    .Out_Data   (Out_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Level      (Level),
    .Overflow   (Overflow),
    .Drop_Count (Drop_Count),
    .Busy       (Busy)
  );

  int tests_run  = 0;
  int tests_fail = 0;
  int valid_cnt  = 0;
  int max_level  = 0;
  int first_v    = -1;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int base, input int r);
    logic [RW-1:0] row;
    row = '0;
    for (int k = 0; k < L; k++) begin
      row[k*W +: W] = W'(base + r * 16 + k);
    end
    return row;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // scoreboard: check every accepted row against the expected queue
  always @(negedge Clk) begin
    if (!Rst && !Flush) begin
      if (Out_Valid) valid_cnt++;
      if (int'(Level) > max_level) max_level = int'(Level);
      if (Out_Valid && Out_Ready) begin
        chk("sb_has_row", RW'(exp_q.size() != 0), RW'(1));
        if (exp_q.size() != 0) chk("sb_row", Out_Data, exp_q.pop_front());
      end
    end
  end

  // driver: rows start on consecutive En edges, lane k carries row c-k
  task automatic run_rows(input int nrows, input int base, input int n_keep,
                          input int stall_at, input bit rdy_dflt,
                          input int rdy_edge, input int rst_at);
    logic [RW-1:0] v;
    int e;
    int r;
    for (int i = 0; i < n_keep; i++) exp_q.push_back(mkrow(base, i));
    e = 0;
    first_v = -1;
    for (int c = 0; c < nrows + L - 1; c++) begin
      En = 1'b1;
      In_Valid = (c < nrows);
      for (int k = 0; k < L; k++) begin
        r = c - k;
        if (r >= 0 && r < nrows) v[k*W +: W] = W'(base + r * 16 + k);
        else v[k*W +: W] = W'($urandom_range(0, 16'hFFFF));
      end
      Result = v;
      Out_Ready = (e == rdy_edge) ? 1'b1 : rdy_dflt;
      cyc();
      if (Out_Valid && first_v < 0) first_v = e;
      e++;
      if (c == rst_at) begin
        Rst = 1'b1;
        In_Valid = 1'b1;
        cyc();
        Rst = 1'b0;
        In_Valid = 1'b0;
        return;
      end
      if (c == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          En = 1'b0;
          In_Valid = 1'($urandom_range(0, 1));
          for (int k = 0; k < L; k++) v[k*W +: W] = W'($urandom_range(0, 16'hFFFF));
          Result = v;
          cyc();
          if (Out_Valid && first_v < 0) first_v = e;
          e++;
        end
      end
    end
    En = 1'b1;
    In_Valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; En = 1'b1; In_Valid = 1'b0; Result = '0; Flush = 1'b0; Out_Ready = 1'b0;
    repeat (2) cyc();
    chk("rst_out_valid", RW'(Out_Valid), RW'(0));
    chk("rst_level",     RW'(Level), RW'(0));
    chk("rst_overflow",  RW'(Overflow), RW'(0));
    chk("rst_drop",      RW'(Drop_Count), RW'(0));
    chk("rst_busy",      RW'(Busy), RW'(0));
    chk("rst_out_data",  Out_Data, '0);
    Rst = 1'b0;
    cyc();

    // 1: single row
    run_rows(1, 16'h0100, 1, -1, 1'b1, -1, -1);
    chk("t1_latency", RW'(first_v), RW'(8));
    chk("t1_level",   RW'(Level), RW'(1));
    chk("t1_busy",    RW'(Busy), RW'(1));
    chk("t1_data",    Out_Data, mkrow(16'h0100, 0));
    cyc();
    chk("t1_level_after", RW'(Level), RW'(0));
    chk("t1_busy_after",  RW'(Busy), RW'(0));
    chk("t1_valid_after", RW'(Out_Valid), RW'(0));
    chk("t1_hold_data",   Out_Data, mkrow(16'h0100, 0));

    // 2: back-to-back rows
    valid_cnt = 0;
    max_level = 0;
    run_rows(9, 0, 9, -1, 1'b1, -1, -1);
    repeat (3) cyc();
    chk("t2_valid_cycles", RW'(valid_cnt), RW'(9));
    chk("t2_max_level",    RW'(max_level), RW'(1));
    chk("t2_level",        RW'(Level), RW'(0));

    // 3: overflow with consumer stalled
    run_rows(10, 16'h1000, 8, -1, 1'b0, -1, -1);
    chk("t3_level",    RW'(Level), RW'(8));
    chk("t3_overflow", RW'(Overflow), RW'(1));
    chk("t3_drop",     RW'(Drop_Count), RW'(2));
    Out_Ready = 1'b1;
    repeat (10) cyc();
    chk("t3_drained",       RW'(Level), RW'(0));
    chk("t3_overflow_kept", RW'(Overflow), RW'(1));
    chk("t3_drop_kept",     RW'(Drop_Count), RW'(2));
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    chk("t3_flush_overflow", RW'(Overflow), RW'(0));
    chk("t3_flush_drop",     RW'(Drop_Count), RW'(0));

    // 4: full FIFO with a pop on the completing edge
    run_rows(9, 16'h2000, 9, -1, 1'b0, 16, -1);
    Out_Ready = 1'b0;
    chk("t4_level",    RW'(Level), RW'(8));
    chk("t4_overflow", RW'(Overflow), RW'(0));
    chk("t4_drop",     RW'(Drop_Count), RW'(0));
    Out_Ready = 1'b1;
    repeat (10) cyc();
    chk("t4_drained", RW'(Level), RW'(0));

    // 5: En stall after lane 4 capture
    run_rows(1, 16'h0100, 1, 4, 1'b1, -1, -1);
    chk("t5_latency", RW'(first_v), RW'(11));
    chk("t5_data",    Out_Data, mkrow(16'h0100, 0));
    cyc();
    chk("t5_level_after", RW'(Level), RW'(0));

    // 6a: Rst after lane 5 capture
    run_rows(1, 16'h0700, 0, -1, 1'b1, -1, 5);
    chk("t6_rst_valid", RW'(Out_Valid), RW'(0));
    chk("t6_rst_level", RW'(Level), RW'(0));
    chk("t6_rst_busy",  RW'(Busy), RW'(0));
    repeat (12) cyc();
    chk("t6_rst_quiet", RW'(Busy), RW'(0));

    // 6b: Flush with three rows queued, pop and In_Valid on the flush edge
    run_rows(3, 16'h3000, 3, -1, 1'b0, -1, -1);
    chk("t6_pre_flush_level", RW'(Level), RW'(3));
    Flush = 1'b1;
    In_Valid = 1'b1;
    Out_Ready = 1'b1;
    cyc();
    Flush = 1'b0;
    In_Valid = 1'b0;
    exp_q.delete();
    chk("t6_flush_valid", RW'(Out_Valid), RW'(0));
    chk("t6_flush_level", RW'(Level), RW'(0));
    chk("t6_flush_busy",  RW'(Busy), RW'(0));
    repeat (12) cyc();
    chk("t6_flush_quiet", RW'(Out_Valid), RW'(0));

    chk("sb_empty", RW'(exp_q.size()), RW'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
Reader end of the systolic array output bus: accepts the skewed per-column Result bus (LANES lanes × WIDTH bits, lane k trails lane 0 by k cycles) and realigns each lane into one complete output row. Aligned rows are buffered in a show-ahead FIFO and presented on a valid/ready stream to memory or writeback logic. Sits directly downstream of the array and shares its Clk/En.

Parameters:
LANES, 9, number of array columns / result lanes
WIDTH, 16, bits per lane result
DEPTH, 8, FIFO depth in aligned rows (power of 2)

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  synchronous active-high reset
En  input  1  array advance enable; 0 freezes skew/capture pipeline
In_Valid  input  1  lane 0 of a new row is valid this cycle
Result  input  LANES*WIDTH  array result bus, lane k = Result[k*WIDTH+:WIDTH]
Flush  input  1  synchronous clear of pipeline, FIFO and status
Out_Data  output  LANES*WIDTH  aligned row, lane k at [k*WIDTH+:WIDTH]
Out_Valid  output  1  Out_Data holds a row
Out_Ready  input  1  consumer accepts row when Out_Valid&Out_Ready
Level  output  $clog2(DEPTH)+1  rows currently in FIFO
Overflow  output  1  sticky: at least one aligned row dropped
Drop_Count  output  8  saturating count of dropped rows
Busy  output  1  any row in flight in skew pipeline or FIFO non-empty

Behaviour:
- Reset (Rst=1 at an edge): Out_Data=0, Out_Valid=0, Level=0, Overflow=0, Drop_Count=0, Busy=0; all skew-pipeline valid bits cleared; in-flight rows discarded. Rst overrides Flush, En and all inputs.
- Flush=1 (Rst=0): same effect as reset on the same edge; a pop or In_Valid in that cycle is ignored.
- Capture pipeline advances only on edges with En=1. Edge counts below are En=1 edges; En=0 edges hold all pipeline state, ignore In_Valid and Result.
- Row tagged at En-edge t when In_Valid=1: lane 0 captured at t, lane k at t+k, lane LANES-1 at t+LANES-1.
- Per-lane alignment: lane k delayed by LANES-1-k registers, so all lanes are coherent at t+LANES-1. Valid tag travels in a LANES-1 deep shift register in parallel.
- Push: at edge t+LANES-1 the aligned row is written into the FIFO. In_Valid may be asserted on every En cycle; up to LANES rows in flight.
- Latency: In_Valid at edge t, Out_Valid=1 in the cycle after edge t+LANES-1 (8 En-edges for LANES=9) if FIFO was empty.
- FIFO is show-ahead: Out_Data = head entry whenever Out_Valid=1; Out_Data holds its value when Out_Valid=0. Pop on edge with Out_Valid&Out_Ready. Output side is independent of En.
- Full: push accepted if Level<DEPTH, or Level=DEPTH with a pop on the same edge (Level unchanged). Otherwise row dropped, Overflow set, Drop_Count+1, saturating at 255.
- Empty: Out_Ready with Out_Valid=0 has no effect; push+pop on an empty FIFO is impossible (pop needs Out_Valid).
- Level: +1 on push only, -1 on pop only, unchanged on both. Pointers wrap modulo DEPTH.
- Busy = any valid tag in skew pipeline OR Level!=0.
- Overflow and Drop_Count clear only on Rst or Flush.

Test Plan:
1. Single row: In_Valid=1 at edge 0, lane k value 0x0100+k presented at edge k, Out_Ready=1 -> Out_Valid rises after edge 8; Out_Data lane k = 0x0100+k; Level 1->0 after pop; Busy falls.
2. Back-to-back: 9 rows with In_Valid every cycle, row r lane k = r*16+k, Out_Ready=1 -> 9 consecutive Out_Valid cycles, rows in order, Level never exceeds 1.
3. Overflow: Out_Ready=0, 10 rows -> Level=8, Overflow=1, Drop_Count=2; then Out_Ready=1 -> rows 0..7 drain in order.
4. Full with pop: Level=8 and Out_Ready=1 on the same edge a row completes -> row accepted, Level stays 8, Overflow stays 0.
5. En stall: En=0 for 3 cycles after lane 4 capture, Result garbage during stall -> output row identical to test 1, Out_Valid delayed 3 cycles.
6. Rst mid-row after lane 5 capture, then Flush with Level=3 in a separate run -> Out_Valid=0, Level=0, Busy=0 next cycle; no stale row ever emitted.
